// File: rtl/rgbstr_pkg.sv
// rgbstr_pkg: the RGB stream word shared by every pixel-pipeline stage.
// It holds the word width, field bit positions, default 640x480@60 timing
// and a packing helper.
// Optional build macro used by the stream source: RGBSTR_TESTPAT_EN.
package rgbstr_pkg;

    // Stream word layout: [25] HS, [24] VS, [23] Active, [22:13] XC, [12:3] YC, [2:0] RGB
    localparam int STR_W      = 26;
    localparam int STR_HS     = 25;
    localparam int STR_VS     = 24;
    localparam int STR_ACTIVE = 23;
    localparam int STR_XC_HI  = 22;
    localparam int STR_XC_LO  = 13;
    localparam int STR_YC_HI  = 12;
    localparam int STR_YC_LO  = 3;
    localparam int STR_RGB_HI = 2;
    localparam int STR_RGB_LO = 0;
    localparam int STR_VGA_HI = 25;
    localparam int STR_VGA_LO = 3;

    // Coordinate counters are 10 bits, so neither total may exceed 1024
    localparam int CNT_W         = 10;
    localparam int CNT_MAX_TOTAL = 1024;

    // Default VGA 640x480@60 timing
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Field order matches the bit layout above (MSB first)
    typedef struct packed {
        logic             hs;
        logic             vs;
        logic             active;
        logic [CNT_W-1:0] xc;
        logic [CNT_W-1:0] yc;
        logic [2:0]       rgb;
    } rgbstr_t;

    // Assemble a flat stream word from its fields
    function automatic logic [STR_W-1:0] rgbstr_pack(
        input logic             hs,
        input logic             vs,
        input logic             active,
        input logic [CNT_W-1:0] xc,
        input logic [CNT_W-1:0] yc,
        input logic [2:0]       rgb
    );
        rgbstr_t w;
        w.hs     = hs;
        w.vs     = vs;
        w.active = active;
        w.xc     = xc;
        w.yc     = yc;
        w.rgb    = rgb;
        return w;
    endfunction

endpackage

// File: rtl/rgbstr_timing.sv
// rgbstr_timing: horizontal/vertical pixel counters for the stream source.
// hc runs 0..H_TOTAL-1, and vc advances each time hc wraps.
// Both counters hold while i_en is low.
module rgbstr_timing
    import rgbstr_pkg::*;
#(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525
) (
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_hc,
    output logic [CNT_W-1:0] o_vc
);

    // A total that does not fit the 10-bit counters is a configuration error
    generate
        if (H_TOTAL > CNT_MAX_TOTAL || V_TOTAL > CNT_MAX_TOTAL || H_TOTAL < 1 || V_TOTAL < 1) begin : g_total_check
            $error("rgbstr_timing: H_TOTAL/V_TOTAL must be within 1..1024");
        end
    endgenerate

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] r_hc;
    logic [CNT_W-1:0] r_vc;

    // Advance raster position; a frame end wraps both counters in the same cycle
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (i_en) begin
            if (r_hc == H_LAST) begin
                r_hc <= '0;
                r_vc <= (r_vc == V_LAST) ? '0 : r_vc + 1'b1;
            end else begin
                r_hc <= r_hc + 1'b1;
            end
        end
    end

    assign o_hc = r_hc;
    assign o_vc = r_vc;

endmodule

// File: rtl/rgbstr_source.sv
// rgbstr_source: head of the pixel pipeline. It generates VGA timing and
// emits one registered 26-bit stream word per enabled pixel clock.
// It also drives frame and line strobes that are aligned with the word.
// Build macro RGBSTR_TESTPAT_EN: active RGB becomes eight 64-pixel colour
// bars taken from XC[8:6] instead of color_bg.
module rgbstr_source
    import rgbstr_pkg::*;
#(
    parameter int         H_ACTIVE = DEF_H_ACTIVE,
    parameter int         H_FP     = DEF_H_FP,
    parameter int         H_SYNC   = DEF_H_SYNC,
    parameter int         H_BP     = DEF_H_BP,
    parameter int         V_ACTIVE = DEF_V_ACTIVE,
    parameter int         V_FP     = DEF_V_FP,
    parameter int         V_SYNC   = DEF_V_SYNC,
    parameter int         V_BP     = DEF_V_BP,
    parameter int         SYNC_POL = 0,
    parameter logic [2:0] color_bg = 3'b000
) (
    input  logic             px_clk,
    input  logic             reset,
    input  logic             en,
    output logic [STR_W-1:0] RGBStr_o,
    output logic             frame_o,
    output logic             line_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Decode bounds use one extra bit so an end value of 1024 cannot alias to 0
    localparam logic [CNT_W:0] H_ACT_END = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0] HS_START  = (CNT_W+1)'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0] HS_END    = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0] V_ACT_END = (CNT_W+1)'(V_ACTIVE);
    localparam logic [CNT_W:0] VS_START  = (CNT_W+1)'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0] VS_END    = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic           SYNC_LVL  = 1'(SYNC_POL);

    logic [CNT_W-1:0] w_hc;
    logic [CNT_W-1:0] w_vc;
    logic [CNT_W:0]   w_hc_x;
    logic [CNT_W:0]   w_vc_x;
    logic             w_active;
    logic             w_hs;
    logic             w_vs;
    logic [2:0]       w_rgb;
    logic [STR_W-1:0] w_word;
    logic [STR_W-1:0] w_idle_word;

    logic [STR_W-1:0] r_str;
    logic             r_frame;
    logic             r_line;

    rgbstr_timing #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_timing (
        .i_clk  (px_clk),
        .i_srst (reset),
        .i_en   (en),
        .o_hc   (w_hc),
        .o_vc   (w_vc)
    );

    assign w_hc_x = {1'b0, w_hc};
    assign w_vc_x = {1'b0, w_vc};

    assign w_active = (w_hc_x < H_ACT_END) && (w_vc_x < V_ACT_END);
    assign w_hs     = (w_hc_x >= HS_START && w_hc_x < HS_END) ? SYNC_LVL : ~SYNC_LVL;
    assign w_vs     = (w_vc_x >= VS_START && w_vc_x < VS_END) ? SYNC_LVL : ~SYNC_LVL;

    // Per-bit colour select; blanking always carries RGB 0 so downstream stages can pass it through
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_rgb
`ifdef RGBSTR_TESTPAT_EN
            assign w_rgb[gi] = w_active & w_hc[6+gi];
`else
            assign w_rgb[gi] = w_active & color_bg[gi];
`endif
        end
    endgenerate

    assign w_word      = rgbstr_pack(w_hs, w_vs, w_active, w_hc, w_vc, w_rgb);
    assign w_idle_word = rgbstr_pack(~SYNC_LVL, ~SYNC_LVL, 1'b0, '0, '0, 3'b000);

    // Register the decoded word; with en low the word holds and strobes drop
    always_ff @(posedge px_clk) begin
        if (reset) begin
            r_str   <= w_idle_word;
            r_frame <= 1'b0;
            r_line  <= 1'b0;
        end else if (en) begin
            r_str   <= w_word;
            r_frame <= (w_hc == '0) && (w_vc == '0);
            r_line  <= (w_hc == '0);
        end else begin
            r_frame <= 1'b0;
            r_line  <= 1'b0;
        end
    end

    assign RGBStr_o = r_str;
    assign frame_o  = r_frame;
    assign line_o   = r_line;

endmodule
